position_overlay: RTL and testbench
===================================

Name: position_overlay

Overview:
- Consumes the object-centre result (x_position, y_position, valid_position) from the position measurement stage.
- Draws a square marker around the tracked object on the live VGA pixel stream.
- Sits between the colour pipeline and the VGA output driver.
- Double-buffers the position so a frame is never drawn with a mid-frame change, and tracks loss of the object across frames.

Parameters:
- INPUT_WIDTH, 11, width of vga_x/vga_y and position inputs
- COLOR_WIDTH, 10, width of each colour channel
- FRAME_X_MAX, 640, first x value outside the visible area; positions >= this are invalid
- FRAME_Y_MAX, 480, first y value outside the visible area; positions >= this are invalid
- BOX_HALF, 8, marker half-size in pixels (outline at distance BOX_HALF from centre)
- LOST_FRAMES, 4, consecutive frames with no valid position before state becomes LOST (>=1)

Ports:
- clk  in  1  pixel clock
- areset  in  1  asynchronous, active-high reset
- enable  in  1  synchronous enable; low forces IDLE and clears buffers
- vga_x  in  INPUT_WIDTH  current pixel x
- vga_y  in  INPUT_WIDTH  current pixel y
- x_position  in  INPUT_WIDTH  measured centre x
- y_position  in  INPUT_WIDTH  measured centre y
- valid_position  in  1  single-cycle pulse qualifying x/y_position
- in_red / in_green / in_blue  in  COLOR_WIDTH each  input pixel colour
- out_red / out_green / out_blue  out  COLOR_WIDTH each  output pixel colour, registered
- tracking  out  1  high while state is TRACK

Behaviour:
- Reset (areset high, async): state IDLE; pending_x/y = 0; pending_flag = 0; active_x/y = 0; miss_count = 0; all out_* = 0; tracking = 0.
- enable low (synchronous): same clearing as reset, except out_* continue as a registered pass-through of in_*.
- Capture: on valid_position with x_position < FRAME_X_MAX and y_position < FRAME_Y_MAX:
  - pending_x/y <= inputs; pending_flag <= 1.
  - A later valid in the same frame overwrites the earlier one.
  - An out-of-range position (e.g. a divide-by-zero result for an empty frame) is ignored and leaves pending untouched.
- SOF event: vga_x == 0 and vga_y == 0, one cycle.
  - If pending_flag: active <= pending; pending_flag <= 0; miss_count <= 0; state <= TRACK.
  - Else: miss_count <= miss_count + 1, saturating at LOST_FRAMES. If the incremented value equals LOST_FRAMES and state is TRACK, state <= LOST.
- Simultaneous valid and SOF: the incoming in-range position bypasses pending, goes straight to active, and state <= TRACK; pending_flag ends at 0.
- State transitions:
  - IDLE -> TRACK on a SOF with pending data.
  - TRACK -> LOST on miss saturation.
  - LOST -> TRACK on a SOF with pending data.
  - No other transitions except reset or enable low -> IDLE.
- Marker test in TRACK only:
  - dx = vga_x - active_x, dy = vga_y - active_y, computed signed at INPUT_WIDTH+1 bits (no wrap).
  - Pixel is marked when |dx| <= BOX_HALF and |dy| <= BOX_HALF and (|dx| == BOX_HALF or |dy| == BOX_HALF).
  - Box parts off-screen are simply never matched (clipping).
- Output, latency exactly 1 clk:
  - Marked pixel: out_red = all ones, out_green = 0, out_blue = 0.
  - Otherwise out_* = in_*.
  - IDLE and LOST: pure pass-through.
- tracking is registered, and updates on the same edge as state.

Optional Feature:
- Macro OVERLAY_CROSSHAIR_EN.
- When defined, pixels with (dx == 0 or dy == 0) inside the box bounds are also marked, drawing a plus sign within the outline. Same colour and latency.
- When undefined, only the outline is drawn; no extra logic.

Test Plan:
- Reset, enable=1, valid pulse x=100, y=50, then SOF -> tracking=1 the cycle after SOF. Pixel (108,50) outputs red one cycle later; pixel (100,50) passes through (and is red with OVERLAY_CROSSHAIR_EN); pixel (109,50) passes through.
- Valid x=200 mid-frame while active=100 -> pixels in the current frame still mark around x=100; after the next SOF the marker is around x=200.
- After TRACK, 4 consecutive frames without valid -> tracking falls at the 4th SOF and output becomes pass-through. A valid followed by SOF restores tracking=1.
- Valid with x_position=2047 -> ignored; state unchanged; no marker change at the next SOF.
- Valid x=3, y=3 (box clips at left/top edge) -> pixel (0,11) and pixel (11,0) marked; no spurious marks near x=2040 from wrap-around.
- areset asserted mid-frame while in TRACK -> outputs 0 and tracking=0 immediately (asynchronously). After release, pass-through with 1-cycle latency until a new valid+SOF.

Source files
------------

// File: rtl/position_overlay.sv
// rtl/position_overlay.sv - square marker overlay on the VGA stream around a double-buffered tracked position.
// Optional plus-sign inside the outline when OVERLAY_CROSSHAIR_EN is defined.
module position_overlay #(
  parameter int INPUT_WIDTH = 11,
  parameter int COLOR_WIDTH = 10,
  parameter int FRAME_X_MAX = 640,
  parameter int FRAME_Y_MAX = 480,
  parameter int BOX_HALF    = 8,
  parameter int LOST_FRAMES = 4
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   enable,
  input  logic [INPUT_WIDTH-1:0] vga_x,
  input  logic [INPUT_WIDTH-1:0] vga_y,
  input  logic [INPUT_WIDTH-1:0] x_position,
  input  logic [INPUT_WIDTH-1:0] y_position,
  input  logic                   valid_position,
  input  logic [COLOR_WIDTH-1:0] in_red,
  input  logic [COLOR_WIDTH-1:0] in_green,
  input  logic [COLOR_WIDTH-1:0] in_blue,
  output logic [COLOR_WIDTH-1:0] out_red,
  output logic [COLOR_WIDTH-1:0] out_green,
  output logic [COLOR_WIDTH-1:0] out_blue,
  output logic                   tracking
);

  localparam int MW = $clog2(LOST_FRAMES + 1);
  localparam logic [MW-1:0]          LP_LOST = MW'(LOST_FRAMES);
  localparam logic [INPUT_WIDTH:0]   LP_HALF = (INPUT_WIDTH + 1)'(BOX_HALF);
  localparam logic [INPUT_WIDTH-1:0] LP_XMAX = INPUT_WIDTH'(FRAME_X_MAX);
  localparam logic [INPUT_WIDTH-1:0] LP_YMAX = INPUT_WIDTH'(FRAME_Y_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_LOST  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [INPUT_WIDTH-1:0] r_pend_x, r_pend_y, r_act_x, r_act_y;
  logic [INPUT_WIDTH-1:0] w_pend_x_nxt, w_pend_y_nxt, w_act_x_nxt, w_act_y_nxt;
  logic                   r_pend_flag, w_pend_flag_nxt;
  logic [MW-1:0]          r_miss, w_miss_nxt, w_miss_inc;
  logic                   r_tracking;
  logic [COLOR_WIDTH-1:0] r_out_red, r_out_green, r_out_blue;

  logic                   w_sof;
  logic                   w_cap;
  logic signed [INPUT_WIDTH:0] w_dx, w_dy;
  logic [INPUT_WIDTH:0]   w_adx, w_ady;
  logic                   w_in_box, w_edge, w_shape, w_mark;

  assign w_sof = (vga_x == '0) && (vga_y == '0);
  assign w_cap = valid_position && (x_position < LP_XMAX) && (y_position < LP_YMAX);

  // One extra bit keeps off-screen parts of the box from wrapping onto the far edge.
  assign w_dx  = $signed({1'b0, vga_x}) - $signed({1'b0, r_act_x});
  assign w_dy  = $signed({1'b0, vga_y}) - $signed({1'b0, r_act_y});
  assign w_adx = w_dx[INPUT_WIDTH] ? $unsigned(-w_dx) : $unsigned(w_dx);
  assign w_ady = w_dy[INPUT_WIDTH] ? $unsigned(-w_dy) : $unsigned(w_dy);

  assign w_in_box = (w_adx <= LP_HALF) && (w_ady <= LP_HALF);
  assign w_edge   = (w_adx == LP_HALF) || (w_ady == LP_HALF);
`ifdef OVERLAY_CROSSHAIR_EN
  assign w_shape  = w_edge || (w_adx == '0) || (w_ady == '0);
`else
  assign w_shape  = w_edge;
`endif
  assign w_mark   = enable && (r_state == ST_TRACK) && w_in_box && w_shape;

  assign w_miss_inc = (r_miss == LP_LOST) ? r_miss : r_miss + MW'(1);

  always_comb begin
    w_state_nxt     = r_state;
    w_pend_x_nxt    = r_pend_x;
    w_pend_y_nxt    = r_pend_y;
    w_pend_flag_nxt = r_pend_flag;
    w_act_x_nxt     = r_act_x;
    w_act_y_nxt     = r_act_y;
    w_miss_nxt      = r_miss;
    if (!enable) begin
      w_state_nxt     = ST_IDLE;
      w_pend_x_nxt    = '0;
      w_pend_y_nxt    = '0;
      w_pend_flag_nxt = 1'b0;
      w_act_x_nxt     = '0;
      w_act_y_nxt     = '0;
      w_miss_nxt      = '0;
    end else if (w_sof) begin
      if (w_cap) begin
        // A position arriving exactly on SOF goes straight to the active buffer.
        w_act_x_nxt     = x_position;
        w_act_y_nxt     = y_position;
        w_pend_flag_nxt = 1'b0;
        w_miss_nxt      = '0;
        w_state_nxt     = ST_TRACK;
      end else if (r_pend_flag) begin
        w_act_x_nxt     = r_pend_x;
        w_act_y_nxt     = r_pend_y;
        w_pend_flag_nxt = 1'b0;
        w_miss_nxt      = '0;
        w_state_nxt     = ST_TRACK;
      end else begin
        w_miss_nxt = w_miss_inc;
        if ((w_miss_inc == LP_LOST) && (r_state == ST_TRACK))
          w_state_nxt = ST_LOST;
      end
    end else if (w_cap) begin
      w_pend_x_nxt    = x_position;
      w_pend_y_nxt    = y_position;
      w_pend_flag_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state     <= ST_IDLE;
      r_pend_x    <= '0;
      r_pend_y    <= '0;
      r_pend_flag <= 1'b0;
      r_act_x     <= '0;
      r_act_y     <= '0;
      r_miss      <= '0;
      r_tracking  <= 1'b0;
      r_out_red   <= '0;
      r_out_green <= '0;
      r_out_blue  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_x    <= w_pend_x_nxt;
      r_pend_y    <= w_pend_y_nxt;
      r_pend_flag <= w_pend_flag_nxt;
      r_act_x     <= w_act_x_nxt;
      r_act_y     <= w_act_y_nxt;
      r_miss      <= w_miss_nxt;
      r_tracking  <= (w_state_nxt == ST_TRACK);
      if (w_mark) begin
        r_out_red   <= '1;
        r_out_green <= '0;
        r_out_blue  <= '0;
      end else begin
        r_out_red   <= in_red;
        r_out_green <= in_green;
        r_out_blue  <= in_blue;
      end
    end
  end

  assign out_red   = r_out_red;
  assign out_green = r_out_green;
  assign out_blue  = r_out_blue;
  assign tracking  = r_tracking;

endmodule

// File: tb/tb_position_overlay.sv
// tb/tb_position_overlay.sv - self-checking bench for position_overlay (marker table plus multi-frame sequences).
module tb_position_overlay;

`ifdef OVERLAY_CROSSHAIR_EN
  localparam bit CH = 1'b1;
`else
  localparam bit CH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        enable = 1'b0;
  logic [10:0] vga_x = 11'd5, vga_y = 11'd5;
  logic [10:0] x_position = '0, y_position = '0;
  logic        valid_position = 1'b0;
  logic [9:0]  in_red = '0, in_green = '0, in_blue = '0;
  logic [9:0]  out_red, out_green, out_blue;
  logic        tracking;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pix    = 0;
  logic [29:0] sb[$];

  typedef struct {
    int vx;
    int vy;
    bit mark;
  } vec_t;
  vec_t tbl[14];

  position_overlay dut (
    .clk(clk), .areset(areset), .enable(enable),
    .vga_x(vga_x), .vga_y(vga_y),
    .x_position(x_position), .y_position(y_position), .valid_position(valid_position),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
    .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
    .tracking(tracking)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic step(input int vx, input int vy, input bit v, input int px, input int py);
    vga_x = 11'(vx);
    vga_y = 11'(vy);
    valid_position = v;
    x_position = 11'(px);
    y_position = 11'(py);
    @(posedge clk);
    #1;
    valid_position = 1'b0;
    vga_x = 11'd5;
    vga_y = 11'd5;
  endtask

  task automatic pix(input string name, input int vx, input int vy, input bit mark);
    logic [29:0] exp;
    n_pix++;
    in_red   = 10'(12'h100 + n_pix * 3);
    in_green = 10'(12'h2A0 - n_pix);
    in_blue  = 10'(12'h055 + n_pix * 7);
    exp = mark ? {10'h3FF, 10'h000, 10'h000} : {in_red, in_green, in_blue};
    sb.push_back(exp);
    step(vx, vy, 1'b0, 0, 0);
    if (sb.size() == 0) check({name, "_sb_empty"}, 32'd1, 32'd0);
    else check(name, {2'b0, out_red, out_green, out_blue}, {2'b0, sb.pop_front()});
  endtask

  initial begin
    tbl[0]  = '{108, 50, 1'b1};
    tbl[1]  = '{100, 50, CH};
    tbl[2]  = '{109, 50, 1'b0};
    tbl[3]  = '{92,  50, 1'b1};
    tbl[4]  = '{91,  50, 1'b0};
    tbl[5]  = '{100, 58, 1'b1};
    tbl[6]  = '{100, 42, 1'b1};
    tbl[7]  = '{100, 59, 1'b0};
    tbl[8]  = '{108, 58, 1'b1};
    tbl[9]  = '{92,  42, 1'b1};
    tbl[10] = '{107, 57, 1'b0};
    tbl[11] = '{104, 50, CH};
    tbl[12] = '{100, 46, CH};
    tbl[13] = '{103, 45, 1'b0};

    // Reset state
    #2;
    check("rst_out", {2'b0, out_red, out_green, out_blue}, 32'd0);
    check("rst_tracking", {31'b0, tracking}, 32'd0);
    @(posedge clk); #3;
    areset = 1'b0;
    enable = 1'b1;
    @(posedge clk); #1;

    pix("idle_pass", 100, 50, 1'b0);
    check("idle_tracking", {31'b0, tracking}, 32'd0);

    // Acquire at (100,50)
    step(20, 20, 1'b1, 100, 50);
    check("pend_no_track", {31'b0, tracking}, 32'd0);
    step(0, 0, 1'b0, 0, 0);
    check("sof_track", {31'b0, tracking}, 32'd1);
    for (int i = 0; i < 14; i++)
      pix($sformatf("tbl%0d_%0d_%0d", i, tbl[i].vx, tbl[i].vy), tbl[i].vx, tbl[i].vy, tbl[i].mark);

    // Mid-frame update is held until next SOF
    step(30, 30, 1'b1, 200, 50);
    pix("mid_old_mark", 108, 50, 1'b1);
    pix("mid_new_none", 208, 50, 1'b0);
    step(0, 0, 1'b0, 0, 0);
    pix("new_mark", 208, 50, 1'b1);
    pix("old_gone", 108, 50, 1'b0);

    // Out-of-range positions ignored; then miss frames
    step(30, 30, 1'b1, 2047, 50);
    step(31, 30, 1'b1, 100, 480);
    step(0, 0, 1'b0, 0, 0);
    check("miss1_tracking", {31'b0, tracking}, 32'd1);
    pix("oor_unchanged", 208, 50, 1'b1);
    pix("oor_no_2047", 108, 50, 1'b0);
    step(0, 0, 1'b0, 0, 0);
    check("miss2_tracking", {31'b0, tracking}, 32'd1);
    step(0, 0, 1'b0, 0, 0);
    check("miss3_tracking", {31'b0, tracking}, 32'd1);
    step(0, 0, 1'b0, 0, 0);
    check("miss4_lost", {31'b0, tracking}, 32'd0);
    pix("lost_pass", 208, 50, 1'b0);
    step(0, 0, 1'b0, 0, 0);
    check("lost_stays", {31'b0, tracking}, 32'd0);

    // Reacquire near the top-left corner: clipping, no wrap
    step(40, 40, 1'b1, 3, 3);
    step(0, 0, 1'b0, 0, 0);
    check("reacq_track", {31'b0, tracking}, 32'd1);
    pix("clip_0_11", 0, 11, 1'b1);
    pix("clip_11_0", 11, 0, 1'b1);
    pix("clip_0_3", 0, 3, CH);
    pix("nowrap_2043_3", 2043, 3, 1'b0);
    pix("nowrap_3_2043", 3, 2043, 1'b0);
    pix("nowrap_2043_2043", 2043, 2043, 1'b0);

    // Valid coincident with SOF bypasses pending
    step(0, 0, 1'b1, 300, 100);
    check("byp_track", {31'b0, tracking}, 32'd1);
    pix("byp_mark_x", 308, 100, 1'b1);
    pix("byp_mark_y", 300, 92, 1'b1);
    step(0, 0, 1'b0, 0, 0);
    check("byp_miss_track", {31'b0, tracking}, 32'd1);
    pix("byp_held", 308, 100, 1'b1);

    // enable low clears state and pending
    step(30, 30, 1'b1, 400, 200);
    enable = 1'b0;
    pix("dis_pass", 308, 100, 1'b0);
    check("dis_tracking", {31'b0, tracking}, 32'd0);
    enable = 1'b1;
    step(0, 0, 1'b0, 0, 0);
    check("dis_pend_cleared", {31'b0, tracking}, 32'd0);
    pix("dis_no_mark", 408, 200, 1'b0);

    // Async reset mid-frame while tracking
    step(30, 30, 1'b1, 50, 60);
    step(0, 0, 1'b0, 0, 0);
    pix("pre_rst_mark", 58, 60, 1'b1);
    step(30, 30, 1'b1, 70, 70);
    #2;
    areset = 1'b1;
    #1;
    check("arst_out", {2'b0, out_red, out_green, out_blue}, 32'd0);
    check("arst_tracking", {31'b0, tracking}, 32'd0);
    #2;
    areset = 1'b0;
    pix("post_rst_pass", 58, 60, 1'b0);
    check("post_rst_tracking", {31'b0, tracking}, 32'd0);
    step(0, 0, 1'b0, 0, 0);
    check("post_rst_pend_cleared", {31'b0, tracking}, 32'd0);
    pix("post_rst_no_mark", 78, 70, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
